// File: rtl/instr_reg_multibyte_pkg.sv
// Shared constants for the multi-byte instruction register: bus geometry, FSM states
// and the operand-length table of the current ISA.
package instr_reg_multibyte_pkg;

  localparam int unsigned IR_DATA_W   = 8;
  localparam int unsigned IR_OPC_W    = 4;
  localparam int unsigned IR_MAX_OPND = 2;
  localparam int unsigned IR_LEN_W    = 2;

  // Operand bytes per opcode: 1,2 -> 1; 4,5 -> 2; 7 -> 3 (saturates to IR_MAX_OPND); others 0.
  localparam logic [31:0] IR_ISA_LEN_TABLE = 32'h0000_CA14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPND  = 2'd1,
    VALID = 2'd2
  } ir_state_e;

endpackage

// File: rtl/instr_reg_multibyte_len_decode.sv
// Combinational opcode -> operand byte count lookup, saturated to MAX_OPND.
module ir_len_decode #(
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned LEN_W    = 2,
  parameter int unsigned MAX_OPND = 2,
  parameter logic [(2**OPC_W)*LEN_W-1:0] LEN_TABLE = '0
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [LEN_W-1:0] len
);

  logic [LEN_W-1:0] raw_len;

  always_comb begin
    raw_len = LEN_TABLE[32'(opcode)*LEN_W +: LEN_W];
    len     = raw_len;
    if (32'(raw_len) > MAX_OPND) begin
      len = LEN_W'(MAX_OPND);
    end
  end

endmodule

// File: rtl/instr_reg_multibyte.sv
// Instruction register: captures an opcode byte then 0..MAX_OPND operand bytes on II strobes,
// and hands the assembled instruction to the control unit with a valid/ack handshake.
module instr_reg_multibyte
  import instr_reg_multibyte_pkg::*;
#(
  parameter int unsigned DATA_W   = IR_DATA_W,
  parameter int unsigned OPC_W    = IR_OPC_W,
  parameter int unsigned MAX_OPND = IR_MAX_OPND,
  parameter int unsigned LEN_W    = IR_LEN_W,
  parameter logic [(2**OPC_W)*LEN_W-1:0] LEN_TABLE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       II,
  input  logic                       flush,
  input  logic                       ack,
  input  logic [DATA_W-1:0]          bus,
  output logic [OPC_W-1:0]           opcode,
  output logic [DATA_W-1:0]          instr_out,
  output logic [MAX_OPND*DATA_W-1:0] operand,
  output logic [LEN_W-1:0]           opnd_len,
  output logic                       instr_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned IDX_W  = $clog2(MAX_OPND + 1);
  localparam int unsigned LOW_W  = DATA_W - OPC_W;
  localparam int unsigned OPND_W = MAX_OPND * DATA_W;

  ir_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OPC_W-1:0]      opcode_d;
  logic [DATA_W-1:0]     instr_out_d;
  logic [OPND_W-1:0]     operand_d;
  logic [LEN_W-1:0]      opnd_len_d;
  logic                  overrun_d;
  logic                  capture;
  logic [LEN_W-1:0]      dec_len;

  ir_len_decode #(
    .OPC_W    (OPC_W),
    .LEN_W    (LEN_W),
    .MAX_OPND (MAX_OPND),
    .LEN_TABLE(LEN_TABLE)
  ) u_len_decode (
    .opcode(bus[DATA_W-1 -: OPC_W]),
    .len   (dec_len)
  );

  // Next-state and next-field logic; flush overrides everything, including a same-cycle II.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    opcode_d    = opcode;
    instr_out_d = instr_out;
    operand_d   = operand;
    opnd_len_d  = opnd_len;
    overrun_d   = 1'b0;
    capture     = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      idx_d       = '0;
      opcode_d    = '0;
      instr_out_d = '0;
      operand_d   = '0;
      opnd_len_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: capture = II;
        OPND: begin
          if (II) begin
            operand_d[32'(idx_q)*DATA_W +: DATA_W] = bus;
            idx_d = idx_q + IDX_W'(1);
            if (32'(idx_q) + 32'd1 == 32'(opnd_len)) begin
              state_d = VALID;
            end
          end
        end
        VALID: begin
          if (ack) begin
            state_d = IDLE;
            capture = II;
          end else if (II) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Opcode capture, shared by IDLE and the acked back-to-back path out of VALID.
      if (capture) begin
        opcode_d    = bus[DATA_W-1 -: OPC_W];
        instr_out_d = DATA_W'(bus[LOW_W-1:0]);
        operand_d   = '0;
        opnd_len_d  = dec_len;
        idx_d       = '0;
        state_d     = (dec_len == '0) ? VALID : OPND;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      opcode      <= '0;
      instr_out   <= '0;
      operand     <= '0;
      opnd_len    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      opcode      <= opcode_d;
      instr_out   <= instr_out_d;
      operand     <= operand_d;
      opnd_len    <= opnd_len_d;
      instr_valid <= (state_d == VALID);
      busy        <= (state_d == OPND);
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_instr_reg_multibyte.sv
// Directed bench for instr_reg_multibyte using the current ISA length table.
module tb_instr_reg_multibyte;
  import instr_reg_multibyte_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        II = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  bus = 8'h00;
  logic [3:0]  opcode;
  logic [7:0]  instr_out;
  logic [15:0] operand;
  logic [1:0]  opnd_len;
  logic        instr_valid;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  instr_reg_multibyte #(
    .DATA_W   (8),
    .OPC_W    (4),
    .MAX_OPND (2),
    .LEN_W    (2),
    .LEN_TABLE(IR_ISA_LEN_TABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .II         (II),
    .flush      (flush),
    .ack        (ack),
    .bus        (bus),
    .opcode     (opcode),
    .instr_out  (instr_out),
    .operand    (operand),
    .opnd_len   (opnd_len),
    .instr_valid(instr_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    II = 1'b1; bus = 8'hFF;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL reset_opcode: got %h want 0", opcode); end
    n_cmp++; if (instr_out !== 8'h00) begin n_err++; $display("FAIL reset_instr_out: got %h want 00", instr_out); end
    n_cmp++; if (operand !== 16'h0000) begin n_err++; $display("FAIL reset_operand: got %h want 0000", operand); end
    n_cmp++; if (opnd_len !== 2'd0) begin n_err++; $display("FAIL reset_opnd_len: got %0d want 0", opnd_len); end
    n_cmp++; if ({instr_valid, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {instr_valid, busy, overrun}); end
    step();
    n_cmp++; if ({instr_valid, busy, opcode} !== 6'h00) begin n_err++; $display("FAIL reset_held: got %h want 00", {instr_valid, busy, opcode}); end
    II = 1'b0; bus = 8'h00;
    rst = 1'b1;
    step();
    n_cmp++; if ({instr_valid, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_release: got %b want 000", {instr_valid, busy, overrun}); end
  endtask

  task automatic test_zero_opnd();
    II = 1'b1; bus = 8'h3A;
    step();
    II = 1'b0;
    n_cmp++; if (opcode !== 4'h3) begin n_err++; $display("FAIL zero_opcode: got %h want 3", opcode); end
    n_cmp++; if (instr_out !== 8'h0A) begin n_err++; $display("FAIL zero_instr_out: got %h want 0a", instr_out); end
    n_cmp++; if ({instr_valid, busy} !== 2'b10) begin n_err++; $display("FAIL zero_valid_busy: got %b want 10", {instr_valid, busy}); end
    n_cmp++; if ({opnd_len, operand} !== 18'h0) begin n_err++; $display("FAIL zero_len_operand: got %h want 0", {opnd_len, operand}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL zero_ack_idle: got %b want 0", instr_valid); end
  endtask

  task automatic test_two_opnd();
    II = 1'b1; bus = 8'h51;
    step();
    n_cmp++; if ({opcode, instr_out, opnd_len} !== {4'h5, 8'h01, 2'd2}) begin n_err++; $display("FAIL two_capture: got %h want %h", {opcode, instr_out, opnd_len}, {4'h5, 8'h01, 2'd2}); end
    n_cmp++; if ({instr_valid, busy} !== 2'b01) begin n_err++; $display("FAIL two_busy: got %b want 01", {instr_valid, busy}); end
    II = 1'b0;
    step();
    n_cmp++; if ({instr_valid, busy} !== 2'b01) begin n_err++; $display("FAIL two_gap_hold: got %b want 01", {instr_valid, busy}); end
    II = 1'b1; bus = 8'h34;
    step();
    n_cmp++; if ({instr_valid, busy, operand} !== {2'b01, 16'h0034}) begin n_err++; $display("FAIL two_first_byte: got %h want %h", {instr_valid, busy, operand}, {2'b01, 16'h0034}); end
    bus = 8'h12;
    step();
    II = 1'b0;
    n_cmp++; if ({instr_valid, busy} !== 2'b10) begin n_err++; $display("FAIL two_valid: got %b want 10", {instr_valid, busy}); end
    n_cmp++; if (operand !== 16'h1234) begin n_err++; $display("FAIL two_operand: got %h want 1234", operand); end
    step();
    n_cmp++; if ({instr_valid, operand, opcode} !== {1'b1, 16'h1234, 4'h5}) begin n_err++; $display("FAIL two_hold_no_ack: got %h want %h", {instr_valid, operand, opcode}, {1'b1, 16'h1234, 4'h5}); end
  endtask

  task automatic test_back_to_back();
    ack = 1'b1; II = 1'b1; bus = 8'h30;
    step();
    ack = 1'b0; II = 1'b0;
    n_cmp++; if ({opcode, instr_out, opnd_len, operand} !== {4'h3, 8'h00, 2'd0, 16'h0}) begin n_err++; $display("FAIL b2b_fields: got %h want %h", {opcode, instr_out, opnd_len, operand}, {4'h3, 8'h00, 2'd0, 16'h0}); end
    n_cmp++; if ({instr_valid, busy, overrun} !== 3'b100) begin n_err++; $display("FAIL b2b_flags: got %b want 100", {instr_valid, busy, overrun}); end
  endtask

  task automatic test_overrun();
    ack = 1'b1; II = 1'b1; bus = 8'h51;
    step();
    ack = 1'b0; bus = 8'hAB;
    step();
    bus = 8'hCD;
    step();
    n_cmp++; if ({instr_valid, operand} !== {1'b1, 16'hCDAB}) begin n_err++; $display("FAIL ovr_setup: got %h want %h", {instr_valid, operand}, {1'b1, 16'hCDAB}); end
    bus = 8'h77;
    step();
    II = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    n_cmp++; if ({opcode, instr_out, operand, instr_valid} !== {4'h5, 8'h01, 16'hCDAB, 1'b1}) begin n_err++; $display("FAIL ovr_unchanged: got %h want %h", {opcode, instr_out, operand, instr_valid}, {4'h5, 8'h01, 16'hCDAB, 1'b1}); end
    step();
    n_cmp++; if ({overrun, instr_valid} !== 2'b01) begin n_err++; $display("FAIL ovr_one_cycle: got %b want 01", {overrun, instr_valid}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack: got %b want 0", instr_valid); end
  endtask

  task automatic test_clamp();
    II = 1'b1; bus = 8'h7F;
    step();
    n_cmp++; if ({opnd_len, busy} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL clamp_len: got %h want %h", {opnd_len, busy}, {2'd2, 1'b1}); end
    bus = 8'h11;
    step();
    bus = 8'h22;
    step();
    II = 1'b0;
    n_cmp++; if ({instr_valid, busy, operand, instr_out} !== {2'b10, 16'h2211, 8'h0F}) begin n_err++; $display("FAIL clamp_valid: got %h want %h", {instr_valid, busy, operand, instr_out}, {2'b10, 16'h2211, 8'h0F}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_ack_outside_valid();
    ack = 1'b1;
    step();
    n_cmp++; if ({instr_valid, busy} !== 2'b00) begin n_err++; $display("FAIL ackidle_flags: got %b want 00", {instr_valid, busy}); end
    II = 1'b1; bus = 8'h10;
    step();
    n_cmp++; if ({busy, opnd_len} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL ackopnd_busy: got %h want %h", {busy, opnd_len}, {1'b1, 2'd1}); end
    ack = 1'b0; bus = 8'h42;
    step();
    II = 1'b0;
    n_cmp++; if ({instr_valid, busy, operand} !== {2'b10, 16'h0042}) begin n_err++; $display("FAIL ack_one_opnd: got %h want %h", {instr_valid, busy, operand}, {2'b10, 16'h0042}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_flush();
    II = 1'b1; bus = 8'h5C;
    step();
    bus = 8'h99;
    step();
    n_cmp++; if ({busy, operand} !== {1'b1, 16'h0099}) begin n_err++; $display("FAIL flush_setup: got %h want %h", {busy, operand}, {1'b1, 16'h0099}); end
    flush = 1'b1; bus = 8'hEE;
    step();
    flush = 1'b0; II = 1'b0;
    n_cmp++; if ({opcode, instr_out, operand, opnd_len} !== 30'h0) begin n_err++; $display("FAIL flush_fields: got %h want 0", {opcode, instr_out, operand, opnd_len}); end
    n_cmp++; if ({instr_valid, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL flush_flags: got %b want 000", {instr_valid, busy, overrun}); end
    step();
    n_cmp++; if ({instr_valid, busy} !== 2'b00) begin n_err++; $display("FAIL flush_stay_idle: got %b want 00", {instr_valid, busy}); end
    II = 1'b1; bus = 8'h3A;
    step();
    flush = 1'b1; bus = 8'h77;
    step();
    flush = 1'b0; II = 1'b0;
    n_cmp++; if ({instr_valid, overrun, opcode} !== 6'h00) begin n_err++; $display("FAIL flush_in_valid: got %h want 00", {instr_valid, overrun, opcode}); end
  endtask

  task automatic test_reset_mid_fetch();
    II = 1'b1; bus = 8'h51;
    step();
    II = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if ({busy, opcode, opnd_len} !== 7'h00) begin n_err++; $display("FAIL rstmid_clear: got %h want 00", {busy, opcode, opnd_len}); end
    step();
    rst = 1'b1;
    II = 1'b1; bus = 8'h34;
    step();
    II = 1'b0;
    n_cmp++; if ({instr_valid, busy, opcode, operand} !== {2'b10, 4'h3, 16'h0}) begin n_err++; $display("FAIL rstmid_fresh: got %h want %h", {instr_valid, busy, opcode, operand}, {2'b10, 4'h3, 16'h0}); end
  endtask

  initial begin
    test_reset();
    test_zero_opnd();
    test_two_opnd();
    test_back_to_back();
    test_overrun();
    test_clamp();
    test_ack_outside_valid();
    test_flush();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
